// File: rtl/fetch_stage.sv
// Instruction-fetch stage of a 5-stage RV32I pipeline.
// It owns the PC and the IF/ID pipeline register. It fetches from a
// variable-latency instruction memory over a req/ack handshake that allows
// one request outstanding at a time.
//
// Handshake: imem_req stays high with imem_addr stable until the single-cycle
// imem_ack strobe, and imem_rdata is valid in the ack cycle. A request that a
// redirect has overtaken is still carried to its ack, but its data is dropped
// ("kill"). The target fetch then issues on the cycle after that ack.
//
// dbg_state_o exposes the FSM state so that checkers can bind to it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        pc_wren,
  input  logic        IFID_wren,
  input  logic        IFID_clear,
  input  logic        br_flush,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic        fetch_busy,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic        kill_q;
  logic [31:0] kill_addr_q;
  logic        skid_valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;

  // A response whose data is live: it belongs to the current PC and has not been killed.
  logic ack_live;
  // The pipeline can accept a new instruction into IF/ID this cycle.
  logic advance;
  logic take_fetch;
  logic take_skid;
  logic to_skid;

  // Decode the handshake and the hazard controls into datapath actions.
  always_comb begin
    ack_live   = (state_q == S_FETCH) && imem_ack && !kill_q;
    advance    = IFID_wren && pc_wren && !IFID_clear && !br_flush;
    take_fetch = ack_live && advance;
    take_skid  = (state_q == S_HOLD) && advance;
    // A clear with an ack in the same cycle parks the ack in the skid buffer, so the instruction is not lost.
    to_skid    = ack_live && !advance && !br_flush;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (to_skid) state_d = S_HOLD;
      S_HOLD:  if (br_flush || take_skid) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. A killed request keeps its original address until it is acked.
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    imem_addr   = kill_q ? kill_addr_q : pc_q;
    fetch_busy  = imem_req && !imem_ack;
    dbg_state_o = state_q;
  end

  // PC: a redirect takes priority, otherwise the PC steps when an instruction enters IF/ID.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q <= RESET_PC;
    end else if (br_flush) begin
      pc_q <= {br_target[31:2], 2'b00};
    end else if (take_fetch || take_skid) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Kill tracking: a redirect during an un-acked request marks that request as dead until its ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      kill_q      <= 1'b0;
      kill_addr_q <= 32'h0;
    end else if (state_q == S_FETCH) begin
      if (imem_ack) begin
        kill_q <= 1'b0;
      end else if (br_flush) begin
        kill_q      <= 1'b1;
        kill_addr_q <= imem_addr;
      end
    end
  end

  // Skid buffer: holds a response that IF/ID could not take; a redirect drops it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
    end else if (br_flush) begin
      skid_valid_q <= 1'b0;
    end else if (to_skid) begin
      skid_valid_q <= 1'b1;
      skid_pc_q    <= pc_q;
      skid_instr_q <= imem_rdata;
    end else if (take_skid) begin
      skid_valid_q <= 1'b0;
    end
  end

  // IF/ID register: clear or flush wins; on write it loads an instruction or a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (br_flush || IFID_clear) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (IFID_wren) begin
      if (take_fetch) begin
        ifid_pc_q    <= pc_q;
        ifid_instr_q <= imem_rdata;
        ifid_valid_q <= 1'b1;
      end else if (take_skid) begin
        ifid_pc_q    <= skid_pc_q;
        ifid_instr_q <= skid_instr_q;
        ifid_valid_q <= 1'b1;
      end else begin
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
      end
    end
  end

  assign IFID_pc    = ifid_pc_q;
  assign IFID_instr = ifid_instr_q;
  assign IFID_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. One instance, u_dut, runs with RESET_PC = 0.
// A second instance, u_dut2, starts near the top of the address space to cover
// PC wrap and a reset asserted in the middle of a wait.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic        pc_wren, IFID_wren, IFID_clear, br_flush;
  logic [31:0] br_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, IFID_valid, fetch_busy;
  logic [31:0] imem_addr, IFID_pc, IFID_instr;
  logic [1:0]  dbg_state;

  logic        en2;
  logic        req2, ack2, valid2, busy2;
  logic [31:0] addr2, rdata2, pc2, instr2;
  logic [1:0]  dbg2;

  fetch_stage u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .pc_wren(pc_wren), .IFID_wren(IFID_wren),
    .IFID_clear(IFID_clear), .br_flush(br_flush), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IFID_pc(IFID_pc), .IFID_instr(IFID_instr),
    .IFID_valid(IFID_valid), .fetch_busy(fetch_busy), .dbg_state_o(dbg_state)
  );

  // Zero-wait memory for the second instance whenever en2 is set.
  assign ack2   = en2 & req2;
  assign rdata2 = addr2 ^ KEY;

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .pc_wren(1'b1), .IFID_wren(1'b1),
    .IFID_clear(1'b0), .br_flush(1'b0), .br_target(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .IFID_pc(pc2), .IFID_instr(instr2),
    .IFID_valid(valid2), .fetch_busy(busy2), .dbg_state_o(dbg2)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic        busy_s;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle of inputs for u_dut, applied at negedge; returns #1 after posedge
  task automatic step(input logic ack, input logic pw, input logic iw,
                      input logic clr, input logic fl, input logic [31:0] tgt);
    @(negedge clk);
    imem_ack   = ack;
    imem_rdata = imem_addr ^ KEY;
    pc_wren    = pw;
    IFID_wren  = iw;
    IFID_clear = clr;
    br_flush   = fl;
    br_target  = tgt;
    #1 busy_s  = fetch_busy;
    @(posedge clk);
    #1;
  endtask

  // pops the next expected IF/ID pc and checks pc/instr/valid
  task automatic expect_valid(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, "_pc"}, IFID_pc, e);
    check({tag, "_instr"}, IFID_instr, e ^ KEY);
    check({tag, "_valid"}, {31'b0, IFID_valid}, 32'd1);
  endtask

  task automatic expect_bubble(input string tag);
    check({tag, "_valid"}, {31'b0, IFID_valid}, 32'd0);
    check({tag, "_nop"}, IFID_instr, NOP);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; en2 = 1'b0;
    pc_wren = 1'b1; IFID_wren = 1'b1; IFID_clear = 1'b0; br_flush = 1'b0;
    br_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'b0, IFID_valid}, 32'd0);
    check("rst_instr", IFID_instr, NOP);
    check("rst_pc",    IFID_pc, 32'h0);
    check("rst_busy",  {31'b0, fetch_busy}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_exit_req",  {31'b0, imem_req}, 32'd1);
    check("idle_exit_addr", imem_addr, 32'h0);

    // 1: zero-wait memory
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    step(1, 1, 1, 0, 0, 0); expect_valid("t1_a");
    step(1, 1, 1, 0, 0, 0); expect_valid("t1_b");

    // 2: ack for 0x8 delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 0);
      check("t2_addr_hold", imem_addr, 32'h8);
      check("t2_busy", {31'b0, busy_s}, 32'd1);
      expect_bubble("t2_bubble");
    end
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    step(1, 1, 1, 0, 0, 0); expect_valid("t2_late");
    step(1, 1, 1, 0, 0, 0); expect_valid("t2_c");

    // 3: load-use stall while the ack for 0x10 arrives
    step(1, 0, 0, 0, 0, 0);
    check("t3_hold_pc", IFID_pc, 32'hC);
    check("t3_hold_valid", {31'b0, IFID_valid}, 32'd1);
    check("t3_req_low", {31'b0, imem_req}, 32'd0);
    check("t3_state_hold", {30'b0, dbg_state}, 32'd2);
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    exp_q.push_back(32'h18); exp_q.push_back(32'h1C);
    step(0, 1, 1, 0, 0, 0); expect_valid("t3_release");
    check("t3_next_addr", imem_addr, 32'h14);
    step(1, 1, 1, 0, 0, 0); expect_valid("t3_14");
    step(1, 1, 1, 0, 0, 0); expect_valid("t3_18");
    step(1, 1, 1, 0, 0, 0); expect_valid("t3_1c");

    // 4: redirect to 0x103 while the fetch of 0x20 is outstanding
    step(0, 1, 1, 1, 1, 32'h0000_0103);
    expect_bubble("t4_flush");
    check("t4_old_addr", imem_addr, 32'h20);
    check("t4_req", {31'b0, imem_req}, 32'd1);
    step(0, 1, 1, 0, 0, 0);
    check("t4_old_addr2", imem_addr, 32'h20);
    expect_bubble("t4_wait");
    step(1, 1, 1, 0, 0, 0);
    expect_bubble("t4_discard");
    check("t4_target_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    step(1, 1, 1, 0, 0, 0); expect_valid("t4_target");

    // 5: redirect and ack in the same cycle
    step(1, 1, 1, 1, 1, 32'h0000_0100);
    expect_bubble("t5_discard");
    check("t5_addr", imem_addr, 32'h100);
    // clear together with an ack: the ack goes to the skid buffer
    step(1, 1, 1, 1, 0, 0);
    expect_bubble("t5_clear");
    check("t5_clear_req", {31'b0, imem_req}, 32'd0);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    step(0, 1, 1, 0, 0, 0); expect_valid("t5_skid_out");
    step(1, 1, 1, 0, 0, 0); expect_valid("t5_next");

    // 6: PC wrap, then reset asserted in the middle of a wait
    @(negedge clk); en2 = 1'b1;
    @(posedge clk); #1;
    check("t6_pc_a", pc2, 32'hFFFF_FFF8);
    check("t6_instr_a", instr2, 32'hFFFF_FFF8 ^ KEY);
    @(posedge clk); #1;
    check("t6_pc_b", pc2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("t6_pc_wrap", pc2, 32'h0);
    check("t6_valid", {31'b0, valid2}, 32'd1);
    @(negedge clk); en2 = 1'b0;
    @(posedge clk); #1;
    check("t6_wait_req", {31'b0, req2}, 32'd1);
    check("t6_wait_addr", addr2, 32'h4);
    #2 rst2_n = 1'b0;
    #1;
    check("t6_arst_req", {31'b0, req2}, 32'd0);
    check("t6_arst_addr", addr2, 32'hFFFF_FFF8);
    check("t6_arst_valid", {31'b0, valid2}, 32'd0);
    check("t6_arst_instr", instr2, NOP);
    check("t6_arst_pc", pc2, 32'h0);
    check("t6_arst_busy", {31'b0, busy2}, 32'd0);
    check("t6_arst_state", {30'b0, dbg2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
